fetch_unit: RTL and testbench

//   Instruction fetch stage of the pico MIPS core. It holds the program counter and drives it
//   to the combinational program memory as the read address. It latches the returned

---
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, program-memory address, instruction register. Redirects land one edge after
// they are seen (one bubble); stall holds everything, halt parks fetch until resume.
module fetch_unit #(
  parameter int                AddrSz        = 6,
  parameter int                InstructionSz = 24,
  parameter logic [AddrSz-1:0] ResetAddr     = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [AddrSz-1:0]        pc_addr,
  input  logic [InstructionSz-1:0] mem_instr,
  input  logic                     stall,
  input  logic                     jump,
  input  logic [AddrSz-1:0]        jump_target,
  input  logic                     branch_taken,
  input  logic [AddrSz-1:0]        branch_offset,
  input  logic                     halt_req,
  input  logic                     resume,
  output logic [InstructionSz-1:0] instr,
  output logic [AddrSz-1:0]        instr_pc,
  output logic                     instr_valid,
  output logic                     halted
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam logic [AddrSz-1:0] PcOne = AddrSz'(1);

  state_e                   state_q, state_d;
  logic [AddrSz-1:0]        pc_q, pc_d;
  logic [InstructionSz-1:0] instr_q, instr_d;
  logic [AddrSz-1:0]        instr_pc_q, instr_pc_d;
  logic                     instr_valid_q, instr_valid_d;
  logic [AddrSz-1:0]        redirect_pc;
  logic                     redirect;

  // Branch offsets are relative to the instruction in IR, not to the fetch PC.
  assign redirect    = jump | branch_taken;
  assign redirect_pc = jump ? jump_target : (instr_pc_q + branch_offset);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
        end else if (halt_req) begin
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          instr_d       = mem_instr;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + PcOne;
        end
        if (halt_req) begin
          state_d       = ST_HALTED;
          instr_valid_d = 1'b0;
        end
      end
      ST_HALTED: begin
        instr_valid_d = 1'b0;
        if (resume && !halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d       = ST_RUN;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= ResetAddr;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign pc_addr     = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a plain behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int AW  = 6;
  localparam int IW  = 24;
  localparam int NPC = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_addr;
  logic [IW-1:0] mem_instr;
  logic          stall, jump, branch_taken, halt_req, resume;
  logic [AW-1:0] jump_target, branch_offset;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid, halted;

  logic [IW-1:0] rom [NPC];

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model state.
  int m_pc, m_instr, m_ipc;
  bit m_valid, m_halted;

  always #5 clk = ~clk;

  assign mem_instr = rom[pc_addr];

  fetch_unit #(.AddrSz(AW), .InstructionSz(IW), .ResetAddr('0)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .mem_instr(mem_instr),
    .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .halt_req(halt_req), .resume(resume),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
  );

  // Model: what one clock edge must do, straight from the fetch rules.
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_halted = 0;
    end else if (m_halted) begin
      m_valid = 0;
      if (resume && !halt_req) m_halted = 0;
    end else begin
      if (jump) begin
        m_pc = int'(jump_target); m_valid = 0;
      end else if (branch_taken) begin
        m_pc = (m_ipc + int'(branch_offset)) % NPC; m_valid = 0;
      end else if (halt_req) begin
        m_valid = 0;
      end else if (!stall) begin
        m_instr = int'(rom[m_pc]); m_ipc = m_pc; m_valid = 1;
        m_pc = (m_pc + 1) % NPC;
      end
      if (halt_req) begin
        m_halted = 1; m_valid = 0;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      cmp("pc_addr", int'(pc_addr), m_pc);
      cmp("instr_valid", int'(instr_valid), int'(m_valid));
      cmp("halted", int'(halted), int'(m_halted));
      cmp("instr_pc", int'(instr_pc), m_ipc);
      cmp("instr", int'(instr), m_instr);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; jump = 0; branch_taken = 0; halt_req = 0; resume = 0;
    jump_target = '0; branch_offset = '0;
  endtask

  initial begin
    for (int i = 0; i < NPC; i++) rom[i] = IW'(i);
    idle();
    reset = 1;
    step(1);
    check_en = 1'b1;
    step(1);
    cmp("lit_reset_pc", int'(pc_addr), 0);
    cmp("lit_reset_valid", int'(instr_valid), 0);
    cmp("lit_reset_instr", int'(instr), 0);
    cmp("lit_reset_halted", int'(halted), 0);

    // 1: free run and wrap
    reset = 0;
    step(1);
    cmp("lit_first_valid", int'(instr_valid), 1);
    cmp("lit_first_ipc", int'(instr_pc), 0);
    step(62);
    cmp("lit_run_pc63", int'(pc_addr), 63);
    step(1);
    cmp("lit_wrap_ipc63", int'(instr_pc), 63);
    cmp("lit_wrap_pc0", int'(pc_addr), 0);
    step(1);
    cmp("lit_wrap_ipc0", int'(instr_pc), 0);
    step(4);
    cmp("lit_pc5", int'(pc_addr), 5);

    // 2: stall at pc=5
    stall = 1;
    step(3);
    cmp("lit_stall_pc", int'(pc_addr), 5);
    cmp("lit_stall_ipc", int'(instr_pc), 4);
    cmp("lit_stall_instr", int'(instr), 4);
    stall = 0;
    step(1);
    cmp("lit_unstall_ipc", int'(instr_pc), 5);

    // 3: backwards branch from instr_pc=10
    step(5);
    cmp("lit_ipc10", int'(instr_pc), 10);
    branch_taken = 1; branch_offset = 6'h3D;
    step(1);
    cmp("lit_br_valid", int'(instr_valid), 0);
    cmp("lit_br_pc", int'(pc_addr), 7);
    idle();
    step(1);
    cmp("lit_br_tgt_ipc", int'(instr_pc), 7);
    cmp("lit_br_tgt_valid", int'(instr_valid), 1);

    // 4: jump beats branch, and overrides stall
    jump = 1; jump_target = 6'd20; branch_taken = 1; branch_offset = 6'd3; stall = 1;
    step(1);
    cmp("lit_jmp_pc", int'(pc_addr), 20);
    cmp("lit_jmp_valid", int'(instr_valid), 0);
    idle();
    step(1);
    cmp("lit_jmp_ipc", int'(instr_pc), 20);

    // 5: halt at pc=12, jump ignored, resume
    jump = 1; jump_target = 6'd12;
    step(1);
    idle();
    halt_req = 1;
    step(1);
    cmp("lit_halt_halted", int'(halted), 1);
    cmp("lit_halt_valid", int'(instr_valid), 0);
    halt_req = 0; jump = 1; jump_target = 6'd40;
    step(5);
    cmp("lit_halt_pc", int'(pc_addr), 12);
    idle();
    resume = 1; halt_req = 1;
    step(1);
    cmp("lit_resume_and_halt", int'(halted), 1);
    halt_req = 0;
    step(1);
    cmp("lit_resume_halted", int'(halted), 0);
    resume = 0;
    step(1);
    cmp("lit_resume_valid", int'(instr_valid), 1);
    cmp("lit_resume_ipc", int'(instr_pc), 12);

    // 6: reset mid-run and while halted
    step(17);
    cmp("lit_pc30", int'(pc_addr), 30);
    reset = 1;
    step(1);
    cmp("lit_rst_run_pc", int'(pc_addr), 0);
    cmp("lit_rst_run_valid", int'(instr_valid), 0);
    cmp("lit_rst_run_instr", int'(instr), 0);
    reset = 0; halt_req = 1;
    step(2);
    halt_req = 0; reset = 1;
    step(1);
    cmp("lit_rst_halt", int'(halted), 0);
    cmp("lit_rst_halt_pc", int'(pc_addr), 0);

    // Randomized traffic over a random ROM.
    for (int i = 0; i < NPC; i++) rom[i] = IW'($urandom);
    step(1);
    reset = 0;
    for (int c = 0; c < 4000; c++) begin
      reset         = ($urandom_range(0, 299) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      jump          = ($urandom_range(0, 15) == 0);
      branch_taken  = ($urandom_range(0, 11) == 0);
      halt_req      = ($urandom_range(0, 24) == 0);
      resume        = ($urandom_range(0, 3) == 0);
      jump_target   = AW'($urandom);
      branch_offset = AW'($urandom);
      step(1);
    end
    idle();
    reset = 0;
    step(2);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
